// File: rtl/alu_share_ctrl.sv
// Round-robin arbiter sharing one combinational ALU between requesters.
// Ops are registered at grant, executed for one cycle, then held as a response.
module alu_share_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int IDW     = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [4*NUM_REQ-1:0] req_ctrl,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  output logic [3:0]           alu_ctrl,
  output logic [31:0]          alu_data1,
  output logic [31:0]          alu_data2,
  input  logic [31:0]          alu_result
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] ptr_nx;
  logic [IDW-1:0] id_r;
  logic [IDW-1:0] gnt_idx;
  logic           gnt_found;
  logic           take;

  logic [3:0]     op_r;
  logic           err_r;
  logic [31:0]    a_r;
  logic [31:0]    b_r;

  logic [3:0]     sel_ctrl;
  logic [31:0]    sel_a;
  logic [31:0]    sel_b;
  logic           sel_legal;

  // Two passes: indices at/above the pointer first, then the wrapped part.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[k] && (IDW'(k) >= rr_ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!gnt_found && req_valid[k] && (IDW'(k) < rr_ptr)) begin
        gnt_found = 1'b1;
        gnt_idx   = IDW'(k);
      end
    end
  end

  assign take = (state == IDLE) && gnt_found;

  always_comb begin
    req_ready = '0;
    sel_ctrl  = 4'd0;
    sel_a     = 32'd0;
    sel_b     = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_idx == IDW'(k)) begin
        req_ready[k] = take;
        sel_ctrl     = req_ctrl[4*k +: 4];
        sel_a        = req_a[32*k +: 32];
        sel_b        = req_b[32*k +: 32];
      end
    end
  end

  assign sel_legal = (sel_ctrl >= 4'd1) && (sel_ctrl <= 4'd6);

  assign ptr_nx = (gnt_idx == IDW'(NUM_REQ - 1)) ? '0
                : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (take)      state_nx = EXEC;
      EXEC:                state_nx = RESP;
      RESP: if (rsp_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  // Illegal codes are replaced by code 1 at latch time so the ALU
  // never sees an undefined opcode.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      id_r   <= '0;
      op_r   <= 4'd1;
      err_r  <= 1'b0;
      a_r    <= 32'd0;
      b_r    <= 32'd0;
    end else if (take) begin
      rr_ptr <= ptr_nx;
      id_r   <= gnt_idx;
      op_r   <= sel_legal ? sel_ctrl : 4'd1;
      err_r  <= !sel_legal;
      a_r    <= sel_a;
      b_r    <= sel_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      unique case (1'b1)
        (state == EXEC): begin
          rsp_valid <= 1'b1;
          rsp_id    <= id_r;
          rsp_data  <= err_r ? 32'd0 : alu_result;
          rsp_err   <= err_r;
        end
        (state == RESP) && rsp_ready: begin
          rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign alu_ctrl  = (state == EXEC) ? op_r : 4'd1;
  assign alu_data1 = a_r;
  assign alu_data2 = b_r;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl with a behavioural ALU model.
// Table-driven single ops plus fairness, backpressure and reset sequences.
module tb_alu_share_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [7:0]  req_ctrl;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  alu_ctrl;
  logic [31:0] alu_data1;
  logic [31:0] alu_data2;
  logic [31:0] alu_result;

  int n_cmp = 0;
  int n_bad = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  alu_share_ctrl #(.NUM_REQ(2), .IDW(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_ctrl(req_ctrl), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_ctrl(alu_ctrl), .alu_data1(alu_data1),
    .alu_data2(alu_data2), .alu_result(alu_result)
  );

  always_comb begin
    case (alu_ctrl)
      4'd1:    alu_result = alu_data1 + alu_data2;
      4'd2:    alu_result = alu_data1 - alu_data2;
      4'd3:    alu_result = alu_data1 & alu_data2;
      4'd4:    alu_result = alu_data1 | alu_data2;
      4'd5:    alu_result = alu_data1 >> alu_data2;
      4'd6:    alu_result = alu_data2 << alu_data1;
      default: alu_result = 32'hDEADBEEF;
    endcase
  end

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      n_cmp++;
      if (alu_ctrl < 4'd1 || alu_ctrl > 4'd6) begin
        n_bad++;
        $display("FAIL alu_ctrl_range: got %0d, expected 1..6", alu_ctrl);
      end
    end
  end

  typedef struct {
    int          id;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t tbl [11];

  task automatic set_req(input int id, input logic [3:0] c,
                         input logic [31:0] a, input logic [31:0] b);
    req_ctrl[4*id +: 4] = c;
    req_a[32*id +: 32]  = a;
    req_b[32*id +: 32]  = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_op(input vec_t v);
    logic [1:0] oh;
    logic       legal;
    oh = 2'b00;
    oh[v.id] = 1'b1;
    legal = (v.ctrl >= 4'd1) && (v.ctrl <= 4'd6);
    @(negedge clk);
    set_req(v.id, v.ctrl, v.a, v.b);
    req_valid = oh;
    #1 chk("grant", 32'(req_ready), 32'(oh));
    @(negedge clk);
    req_valid = 2'b00;
    set_req(v.id, 4'd3, $urandom, $urandom);
    #1;
    chk("exec_ready0", 32'(req_ready), 32'd0);
    chk("exec_rspv0", 32'(rsp_valid), 32'd0);
    chk("exec_alu_ctrl", 32'(alu_ctrl), legal ? 32'(v.ctrl) : 32'd1);
    chk("exec_d1", alu_data1, v.a);
    chk("exec_d2", alu_data2, v.b);
    @(negedge clk);
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_id", 32'(rsp_id), 32'(v.id));
    chk("rsp_data", rsp_data, v.exp_data);
    chk("rsp_err", 32'(rsp_err), 32'(v.exp_err));
  endtask

  int g_idx [8];
  int g_cyc [8];
  int r_id  [8];
  logic [31:0] r_dat [8];
  int ng, nr;

  initial begin
    tbl[0]  = '{0, 4'd1,  32'd5,      32'd7,      32'd12,         1'b0};
    tbl[1]  = '{1, 4'd2,  32'd3,      32'd5,      32'hFFFFFFFE,   1'b0};
    tbl[2]  = '{1, 4'd6,  32'd4,      32'd1,      32'd16,         1'b0};
    tbl[3]  = '{1, 4'd5,  32'h80,     32'd3,      32'h10,         1'b0};
    tbl[4]  = '{0, 4'd0,  32'd9,      32'd9,      32'd0,          1'b1};
    tbl[5]  = '{0, 4'd9,  32'd10,     32'd20,     32'd0,          1'b1};
    tbl[6]  = '{0, 4'd3,  32'hF0F0,   32'hFF00,   32'hF000,       1'b0};
    tbl[7]  = '{1, 4'd4,  32'hF0,     32'h0F,     32'hFF,         1'b0};
    tbl[8]  = '{0, 4'd5,  32'd1,      32'd32,     32'd0,          1'b0};
    tbl[9]  = '{1, 4'd6,  32'd40,     32'd1,      32'd0,          1'b0};
    tbl[10] = '{0, 4'd15, 32'd1,      32'd1,      32'd0,          1'b1};

    rst = 1'b1;
    req_valid = 2'b00;
    req_ctrl = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    do_reset();
    mon_en = 1'b1;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'd1);
    chk("rst_alu_d1", alu_data1, 32'd0);
    chk("rst_alu_d2", alu_data2, 32'd0);

    for (int i = 0; i < 11; i++) do_op(tbl[i]);

    // Last grant went to requester 0, so the pointer is 1 before reset.
    do_reset();
    set_req(0, 4'd1, 32'd10, 32'd1);
    set_req(1, 4'd1, 32'd20, 32'd1);
    req_valid = 2'b11;
    ng = 0;
    nr = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (req_ready != 2'b00 && ng < 8) begin
        g_idx[ng] = req_ready[1] ? 1 : 0;
        g_cyc[ng] = c;
        ng++;
      end
      if (rsp_valid && nr < 8) begin
        r_id[nr]  = int'(rsp_id);
        r_dat[nr] = rsp_data;
        nr++;
      end
      @(negedge clk);
    end
    req_valid = 2'b00;
    chk("fair_ngrants", 32'(ng >= 4), 32'd1);
    chk("fair_nrsp", 32'(nr >= 4), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) begin
        chk("fair_grant", 32'(g_idx[i]), 32'(i % 2));
        if (i > 0) chk("fair_gap", 32'(g_cyc[i] - g_cyc[i-1]), 32'd3);
      end
      if (i < nr) begin
        chk("fair_rsp_id", 32'(r_id[i]), 32'(i % 2));
        chk("fair_rsp_data", r_dat[i], (i % 2 == 0) ? 32'd11 : 32'd21);
      end
    end
    repeat (4) @(negedge clk);

    rsp_ready = 1'b0;
    set_req(0, 4'd2, 32'd50, 32'd8);
    req_valid = 2'b01;
    #1 chk("bp_grant0", 32'(req_ready), 32'b01);
    @(negedge clk);
    set_req(1, 4'd4, 32'd1, 32'd2);
    req_valid = 2'b10;
    #1 chk("bp_exec_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_data", rsp_data, 32'd42);
      chk("bp_id", 32'(rsp_id), 32'd0);
      chk("bp_err", 32'(rsp_err), 32'd0);
      chk("bp_ready0", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1 chk("bp_hs_ready0", 32'(req_ready), 32'd0);
    @(negedge clk);
    #1;
    chk("bp_after_valid", 32'(rsp_valid), 32'd0);
    chk("bp_grant1", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("bp_rsp2_valid", 32'(rsp_valid), 32'd1);
    chk("bp_rsp2_id", 32'(rsp_id), 32'd1);
    chk("bp_rsp2_data", rsp_data, 32'd3);

    @(negedge clk);
    set_req(0, 4'd1, 32'd7, 32'd7);
    req_valid = 2'b01;
    #1 chk("rx_grant0", 32'(req_ready), 32'b01);
    @(negedge clk);
    rst = 1'b1;
    set_req(1, 4'd1, 32'd100, 32'd1);
    req_valid = 2'b10;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rx_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rx_rsp_data", rsp_data, 32'd0);
    chk("rx_alu_ctrl", 32'(alu_ctrl), 32'd1);
    chk("rx_grant1", 32'(req_ready), 32'b10);
    @(negedge clk);
    req_valid = 2'b00;
    #1 chk("rx_no_stale", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    #1;
    chk("rx_rsp_valid2", 32'(rsp_valid), 32'd1);
    chk("rx_rsp_id", 32'(rsp_id), 32'd1);
    chk("rx_rsp_data2", rsp_data, 32'd101);

    // Both valid right after reset: pointer restarts at requester 0.
    do_reset();
    set_req(0, 4'd1, 32'd1, 32'd1);
    set_req(1, 4'd1, 32'd2, 32'd2);
    req_valid = 2'b11;
    #1 chk("rx_ptr_zero", 32'(req_ready), 32'b01);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_share_ctrl.md
Name: alu_share_ctrl

Overview:
- Round-robin controller that shares the single-cycle combinational ALU (ctrl codes 1..6) between NUM_REQ requesters.
- Each requester presents an opcode and two 32-bit operands with a valid/ready handshake.
- The controller drives the ALU from registered operands, captures its result, and returns it with the requester ID on one response channel.
- Sits between the decode/issue logic and the ALU instance.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- IDW, 2, width of the requester ID field (must satisfy 2^IDW >= NUM_REQ).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester grant/accept, one-hot or zero.
- req_ctrl  input  4*NUM_REQ  packed opcodes; requester i occupies bits [4i+3:4i].
- req_a  input  32*NUM_REQ  packed operand 1 (data1).
- req_b  input  32*NUM_REQ  packed operand 2 (data2).
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the requester that issued the op.
- rsp_data  output  32  ALU result.
- rsp_err  output  1  opcode was illegal (0 or 7..15).
- alu_ctrl  output  4  to ALU ctrl.
- alu_data1  output  32  to ALU data1.
- alu_data2  output  32  to ALU data2.
- alu_result  input  32  from ALU write_data.

Behaviour:
- FSM states: IDLE, EXEC, RESP.
- Reset (rst=1 at a clock edge):
  - state=IDLE, rr_ptr=0.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0.
  - Operand registers 0, op register 1.
  - Reset mid-operation abandons the in-flight op; no response is produced.
- IDLE:
  - Search req_valid starting at index rr_ptr, wrapping modulo NUM_REQ. The first set bit g is granted.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - req_ready is 0 in every bit outside IDLE.
  - On that edge: latch req_ctrl[g], req_a[g], req_b[g]; set id_r=g; rr_ptr <= (g+1) mod NUM_REQ; go to EXEC.
  - If no req_valid bit is set: stay in IDLE, rr_ptr unchanged.
- EXEC (exactly 1 cycle):
  - alu_ctrl, alu_data1 and alu_data2 are driven from the latched registers, unmodified. The operand order is not swapped for shifts: code 5 yields data1>>data2 and code 6 yields data2<<data1. Shift amounts >=32 give 0.
  - At the edge: rsp_data <= alu_result, rsp_id <= id_r, rsp_err <= 0, rsp_valid <= 1; go to RESP.
  - Illegal opcode: alu_ctrl is driven 1 (never an undefined code, so the ALU never holds a stale value). At the edge: rsp_data <= 0, rsp_err <= 1. Latency is unchanged.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready=1.
  - On the edge where rsp_ready=1: rsp_valid <= 0; go to IDLE.
  - No new grant occurs in that cycle.
- ALU port values outside EXEC:
  - alu_ctrl = 1.
  - alu_data1 and alu_data2 hold the last latched operands. Their value is don't-care to consumers, but must be defined (no X after reset).
- Latency and throughput:
  - Grant at edge T -> rsp_valid high after edge T+2.
  - Minimum issue interval is 3 cycles with rsp_ready tied 1.
- Fairness: a requester continuously asserting valid is granted within NUM_REQ grants.
- Requester rules: a requester may drop req_valid before being granted; the controller samples it only at the grant edge. Operands may change freely after the grant edge.
- Simultaneous requests: only one grant per IDLE cycle; the others wait.
- Opcode width: the full 4-bit field is compared; any value outside 1..6 is illegal.

Test Plan:
- Reset, then requester 0 issues ctrl=1, a=5, b=7 -> req_ready[0] pulses 1 cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_data=12, rsp_err=0.
- Requester 1 issues ctrl=2, a=3, b=5 -> rsp_data=0xFFFFFFFE. Then ctrl=6, a=4, b=1 -> rsp_data=16. Then ctrl=5, a=0x80, b=3 -> rsp_data=0x10.
- Both requesters hold valid continuously with rsp_ready=1 -> grants alternate 0,1,0,1; rsp_id sequence matches; each grant is 3 cycles apart.
- Requester 0 issues ctrl=0, then ctrl=9 -> rsp_err=1, rsp_data=0, alu_ctrl never observed outside 1..6.
- Hold rsp_ready=0 for 5 cycles during RESP with a new request pending -> rsp fields stable, req_ready stays 0; grant happens only after the response handshake.
- Assert rst during EXEC -> next cycle rsp_valid=0, state IDLE, rr_ptr=0; a pending request from requester 1 alone is granted next; no stale response appears.
